// File: rtl/dccm_port_arbiter_pkg.sv
// rtl/dccm_port_arbiter_pkg.sv - shared types for the DCCM port arbiter
package brq_dccm_pkg;

  localparam int DCCM_DW = 32;
  localparam int DCCM_AW = 15;

  typedef enum logic [2:0] {
    BE_B0  = 3'd0,
    BE_B1  = 3'd1,
    BE_B2  = 3'd2,
    BE_B3  = 3'd3,
    BE_HHI = 3'd4,
    BE_HLO = 3'd5,
    BE_W   = 3'd6,
    BE_ILL = 3'd7
  } be_e;

  typedef enum logic {
    ST_CPRI   = 1'b0,
    ST_DFORCE = 1'b1
  } arb_st_e;

  typedef struct packed {
    logic                 we;
    be_e                  be;
    logic [DCCM_AW-1:0]   addr;
    logic [DCCM_DW-1:0]   wdata;
  } dccm_req_t;

endpackage

// File: rtl/dccm_port_arbiter_starve_ctr.sv
// rtl/dccm_port_arbiter_starve_ctr.sv - saturating count of denied D cycles
module dccm_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_deny,
  output logic o_at_max
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // Count while D is denied (saturating); any non-denied cycle restarts the wait
  always_comb begin
    w_cnt_nxt = '0;
    if (i_deny) begin
      w_cnt_nxt = (r_cnt == MAX_C) ? r_cnt : r_cnt + 1'b1;
    end
  end

  // Flag looks at the updated count so the forced grant lands on the next cycle
  always_comb begin
    o_at_max = (w_cnt_nxt == MAX_C);
  end

  // Counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

endmodule

// File: rtl/dccm_port_arbiter.sv
// rtl/dccm_port_arbiter.sv - two-port (core/DMA) arbiter for the single-port DCCM
module dccm_port_arbiter
  import brq_dccm_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 c_req_valid,
  output logic                 c_req_ready,
  input  logic                 c_we,
  input  logic [2:0]           c_be,
  input  logic [AddrWidth-1:0] c_addr,
  input  logic [DataWidth-1:0] c_wdata,
  output logic                 c_rsp_valid,
  output logic [DataWidth-1:0] c_rdata,
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic                 d_we,
  input  logic [2:0]           d_be,
  input  logic [AddrWidth-1:0] d_addr,
  input  logic [DataWidth-1:0] d_wdata,
  output logic                 d_rsp_valid,
  output logic [DataWidth-1:0] d_rdata,
  output logic [AddrWidth-1:0] dccm_address,
  output logic [2:0]           dccm_byte_enable,
  output logic [DataWidth-1:0] dccm_data_in,
  output logic                 dccm_write_enable,
  output logic                 dccm_read_enable,
  input  logic [DataWidth-1:0] dccm_data_out
);

  arb_st_e   r_state;
  arb_st_e   w_state_nxt;
  logic      w_d_prio;
  logic      w_c_gnt;
  logic      w_d_gnt;
  logic      w_any_gnt;
  logic      w_d_deny;
  logic      w_at_max;
  dccm_req_t w_c_req;
  dccm_req_t w_d_req;
  dccm_req_t w_sel;
  logic                 r_c_rsp_valid;
  logic                 r_d_rsp_valid;
  logic [DataWidth-1:0] r_c_rdata;
  logic [DataWidth-1:0] r_d_rdata;

  dccm_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .i_clk    (brq_clk),
    .i_rst    (brq_rst),
    .i_deny   (w_d_deny),
    .o_at_max (w_at_max)
  );

  // FSM state register
  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) r_state <= ST_CPRI;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: force D after the wait threshold, return once D is served or gone
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CPRI:   if (w_at_max) w_state_nxt = ST_DFORCE;
      ST_DFORCE: if (w_d_gnt || !d_req_valid) w_state_nxt = ST_CPRI;
      default:   w_state_nxt = ST_CPRI;
    endcase
  end

  // FSM output: which port wins a conflict
  always_comb begin
    w_d_prio = (r_state == ST_DFORCE);
  end

  // Grants; nothing is honoured while reset is asserted
  always_comb begin
    w_c_gnt   = !brq_rst && c_req_valid && (!d_req_valid || !w_d_prio);
    w_d_gnt   = !brq_rst && d_req_valid && (!c_req_valid || w_d_prio);
    w_any_gnt = w_c_gnt || w_d_gnt;
    w_d_deny  = d_req_valid && !w_d_gnt;
    c_req_ready = w_c_gnt;
    d_req_ready = w_d_gnt;
  end

  // Request mux onto the DCCM pins; illegal byte enables never write
  always_comb begin
    w_c_req = '{we: c_we, be: be_e'(c_be), addr: c_addr, wdata: c_wdata};
    w_d_req = '{we: d_we, be: be_e'(d_be), addr: d_addr, wdata: d_wdata};
    w_sel   = w_d_gnt ? w_d_req : w_c_req;
    dccm_address      = w_any_gnt ? w_sel.addr  : '0;
    dccm_byte_enable  = w_any_gnt ? w_sel.be    : 3'b000;
    dccm_data_in      = w_any_gnt ? w_sel.wdata : '0;
    dccm_write_enable = w_any_gnt && w_sel.we && (w_sel.be != BE_ILL);
    dccm_read_enable  = w_any_gnt && !w_sel.we;
  end

  // Core load response: capture read data at the end of the grant cycle
  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      r_c_rsp_valid <= 1'b0;
      r_c_rdata     <= '0;
    end else begin
      r_c_rsp_valid <= w_c_gnt && !c_we;
      if (w_c_gnt && !c_we) r_c_rdata <= dccm_data_out;
    end
  end

  // DMA load response: capture read data at the end of the grant cycle
  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      r_d_rsp_valid <= 1'b0;
      r_d_rdata     <= '0;
    end else begin
      r_d_rsp_valid <= w_d_gnt && !d_we;
      if (w_d_gnt && !d_we) r_d_rdata <= dccm_data_out;
    end
  end

  // Response outputs
  always_comb begin
    c_rsp_valid = r_c_rsp_valid;
    c_rdata     = r_c_rdata;
    d_rsp_valid = r_d_rsp_valid;
    d_rdata     = r_d_rdata;
  end

endmodule

// File: tb/tb_dccm_port_arbiter.sv
// tb/tb_dccm_port_arbiter.sv - directed self-checking bench for dccm_port_arbiter
module tb_dccm_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 15;

  logic          brq_clk = 1'b0;
  logic          brq_rst = 1'b1;
  logic          c_req_valid = 1'b0, c_req_ready, c_we = 1'b0, c_rsp_valid;
  logic [2:0]    c_be = 3'd6;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0, c_rdata;
  logic          d_req_valid = 1'b0, d_req_ready, d_we = 1'b0, d_rsp_valid;
  logic [2:0]    d_be = 3'd6;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0, d_rdata;
  logic [AW-1:0] dccm_address;
  logic [2:0]    dccm_byte_enable;
  logic [DW-1:0] dccm_data_in, dccm_data_out;
  logic          dccm_write_enable, dccm_read_enable;

  logic [DW-1:0] mem [0:31];
  logic          pl_en = 1'b0;
  logic [4:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  int checks = 0;
  int failures = 0;

  dccm_port_arbiter #(.DataWidth(DW), .AddrWidth(AW), .MAX_WAIT(4)) dut (
    .brq_clk(brq_clk), .brq_rst(brq_rst),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_we(c_we), .c_be(c_be),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_be(d_be),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .dccm_address(dccm_address), .dccm_byte_enable(dccm_byte_enable),
    .dccm_data_in(dccm_data_in), .dccm_write_enable(dccm_write_enable),
    .dccm_read_enable(dccm_read_enable), .dccm_data_out(dccm_data_out)
  );

  always #5 brq_clk = ~brq_clk;

  // DCCM model: combinational read, lane-placed write at the clock edge
  assign dccm_data_out = mem[dccm_address[4:0]];
  always @(posedge brq_clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (dccm_write_enable) begin
      case (dccm_byte_enable)
        3'd0: mem[dccm_address[4:0]][7:0]   <= dccm_data_in[7:0];
        3'd1: mem[dccm_address[4:0]][15:8]  <= dccm_data_in[7:0];
        3'd2: mem[dccm_address[4:0]][23:16] <= dccm_data_in[7:0];
        3'd3: mem[dccm_address[4:0]][31:24] <= dccm_data_in[7:0];
        3'd4: mem[dccm_address[4:0]][31:16] <= dccm_data_in[15:0];
        3'd5: mem[dccm_address[4:0]][15:0]  <= dccm_data_in[15:0];
        3'd6: mem[dccm_address[4:0]]        <= dccm_data_in;
        default: ;
      endcase
    end
  end

  task automatic cyc();
    @(posedge brq_clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [DW-1:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    cyc();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    brq_rst = 1'b1;
    c_req_valid = 1'b1; d_req_valid = 1'b1; c_we = 1'b1; d_we = 1'b0;
    cyc(); cyc();
    #1;
    checks++; if (c_req_ready !== 1'b0) begin failures++; $display("FAIL rst_c_ready got=%b exp=0", c_req_ready); end
    checks++; if (d_req_ready !== 1'b0) begin failures++; $display("FAIL rst_d_ready got=%b exp=0", d_req_ready); end
    checks++; if (dccm_write_enable !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", dccm_write_enable); end
    checks++; if (dccm_read_enable !== 1'b0) begin failures++; $display("FAIL rst_re got=%b exp=0", dccm_read_enable); end
    checks++; if (c_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp got=%b%b exp=00", c_rsp_valid, d_rsp_valid); end
    checks++; if (c_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0", c_rdata, d_rdata); end
    c_req_valid = 1'b0; d_req_valid = 1'b0; c_we = 1'b0;
    cyc();
    brq_rst = 1'b0;
    cyc();
  endtask

  task automatic test_c_load();
    preload(5'h10, 32'hDEADBEEF);
    c_req_valid = 1'b1; c_we = 1'b0; c_addr = 15'h10;
    #1;
    checks++; if (c_req_ready !== 1'b1) begin failures++; $display("FAIL t1_ready got=%b exp=1", c_req_ready); end
    checks++; if (dccm_read_enable !== 1'b1 || dccm_address !== 15'h10) begin failures++; $display("FAIL t1_pins got re=%b a=%h exp re=1 a=10", dccm_read_enable, dccm_address); end
    cyc();
    c_req_valid = 1'b0;
    #1;
    checks++; if (c_rsp_valid !== 1'b1) begin failures++; $display("FAIL t1_rsp_valid got=%b exp=1", c_rsp_valid); end
    checks++; if (c_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL t1_rdata got=%h exp=deadbeef", c_rdata); end
    cyc();
    checks++; if (c_rsp_valid !== 1'b0) begin failures++; $display("FAIL t1_rsp_pulse got=%b exp=0", c_rsp_valid); end
  endtask

  task automatic test_conflict();
    bit prev_c = 1'b0, prev_d = 1'b0, exp_d;
    preload(5'd1, 32'h11111111);
    preload(5'd2, 32'h22222222);
    c_req_valid = 1'b1; c_we = 1'b0; c_addr = 15'd1;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 15'd2;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_d = ((i % 5) == 4);
      checks++; if (d_req_ready !== exp_d || c_req_ready !== !exp_d) begin failures++; $display("FAIL t2_grant cyc=%0d got c=%b d=%b exp d=%b", i, c_req_ready, d_req_ready, exp_d); end
      if (i > 0) begin
        checks++; if (c_rsp_valid !== prev_c || d_rsp_valid !== prev_d) begin failures++; $display("FAIL t2_rsp cyc=%0d got c=%b d=%b exp c=%b d=%b", i, c_rsp_valid, d_rsp_valid, prev_c, prev_d); end
      end
      if (prev_d) begin
        checks++; if (d_rdata !== 32'h22222222) begin failures++; $display("FAIL t2_d_rdata got=%h exp=22222222", d_rdata); end
      end
      prev_c = !exp_d; prev_d = exp_d;
      cyc();
    end
    c_req_valid = 1'b0; d_req_valid = 1'b0;
    #1;
    checks++; if (d_rsp_valid !== 1'b1 || d_rdata !== 32'h22222222) begin failures++; $display("FAIL t2_last_d got v=%b d=%h exp v=1 d=22222222", d_rsp_valid, d_rdata); end
    cyc();
  endtask

  task automatic test_byte_half();
    preload(5'd5, 32'h0);
    d_req_valid = 1'b1; d_we = 1'b1; d_be = 3'b010; d_addr = 15'd5; d_wdata = 32'hAB;
    #1;
    checks++; if (d_req_ready !== 1'b1 || dccm_write_enable !== 1'b1 || dccm_byte_enable !== 3'b010) begin failures++; $display("FAIL t3_d_store got rdy=%b we=%b be=%b exp 1 1 010", d_req_ready, dccm_write_enable, dccm_byte_enable); end
    cyc();
    d_req_valid = 1'b0;
    c_req_valid = 1'b1; c_we = 1'b1; c_be = 3'b100; c_addr = 15'd5; c_wdata = 32'h1234;
    #1;
    checks++; if (dccm_data_in !== 32'h1234 || dccm_byte_enable !== 3'b100) begin failures++; $display("FAIL t3_c_store got din=%h be=%b exp 1234 100", dccm_data_in, dccm_byte_enable); end
    cyc();
    c_we = 1'b0;
    cyc();
    c_req_valid = 1'b0;
    #1;
    checks++; if (c_rsp_valid !== 1'b1 || c_rdata !== 32'h12340000) begin failures++; $display("FAIL t3_readback got v=%b d=%h exp v=1 d=12340000", c_rsp_valid, c_rdata); end
    cyc();
  endtask

  task automatic test_illegal_be();
    preload(5'd6, 32'h5A5A5A5A);
    c_req_valid = 1'b1; c_we = 1'b1; c_be = 3'b111; c_addr = 15'd6; c_wdata = 32'hFFFFFFFF;
    #1;
    checks++; if (c_req_ready !== 1'b1) begin failures++; $display("FAIL t4_ready got=%b exp=1", c_req_ready); end
    checks++; if (dccm_write_enable !== 1'b0) begin failures++; $display("FAIL t4_we got=%b exp=0", dccm_write_enable); end
    cyc();
    c_we = 1'b0; c_be = 3'b110;
    cyc();
    c_req_valid = 1'b0;
    #1;
    checks++; if (c_rsp_valid !== 1'b1 || c_rdata !== 32'h5A5A5A5A) begin failures++; $display("FAIL t4_readback got v=%b d=%h exp v=1 d=5a5a5a5a", c_rsp_valid, c_rdata); end
    cyc();
  endtask

  task automatic test_back_to_back_wr_rd();
    c_req_valid = 1'b1; c_we = 1'b1; c_be = 3'b110; c_addr = 15'd3; c_wdata = 32'hCAFEF00D;
    cyc();
    c_req_valid = 1'b0; c_we = 1'b0;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 15'd3;
    #1;
    checks++; if (d_req_ready !== 1'b1 || dccm_read_enable !== 1'b1) begin failures++; $display("FAIL t5_d_grant got rdy=%b re=%b exp 1 1", d_req_ready, dccm_read_enable); end
    cyc();
    d_req_valid = 1'b0;
    #1;
    checks++; if (d_rsp_valid !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL t5_rdata got v=%b d=%h exp v=1 d=cafef00d", d_rsp_valid, d_rdata); end
    checks++; if (c_rsp_valid !== 1'b0) begin failures++; $display("FAIL t5_no_store_rsp got=%b exp=0", c_rsp_valid); end
    cyc();
  endtask

  task automatic test_reset_midop();
    c_req_valid = 1'b1; c_we = 1'b0; c_addr = 15'd1;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 15'd2;
    cyc(); cyc(); cyc();
    c_req_valid = 1'b0; d_req_valid = 1'b0;
    #1;
    checks++; if (c_rsp_valid !== 1'b1) begin failures++; $display("FAIL t6_pre_rsp got=%b exp=1", c_rsp_valid); end
    brq_rst = 1'b1;
    #1;
    checks++; if (c_rsp_valid !== 1'b0 || c_rdata !== 32'h0) begin failures++; $display("FAIL t6_async_drop got v=%b d=%h exp v=0 d=0", c_rsp_valid, c_rdata); end
    cyc(); cyc();
    brq_rst = 1'b0;
    c_req_valid = 1'b1; d_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (d_req_ready !== (i == 4) || c_req_ready !== (i != 4)) begin failures++; $display("FAIL t6_post_rst cyc=%0d got c=%b d=%b exp d=%b", i, c_req_ready, d_req_ready, (i == 4)); end
      cyc();
    end
    c_req_valid = 1'b0; d_req_valid = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_c_load();
    test_conflict();
    test_byte_half();
    test_illegal_be();
    test_back_to_back_wr_rd();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
